ram_burst_reader: RTL and testbench
===================================

Name: ram_burst_reader

Overview:
- Read-side engine for the receive path's single-clock dual-port sample/symbol RAMs.
- Accepts a burst command (start address, word count) and drives one RAM port: enable, address, with write strobe tied low.
- Absorbs the RAM's one-cycle registered read latency and presents the words as a valid/ready stream with a last marker and a completion pulse.
- Sits between a RAM filled by an upstream writer and downstream consumers (demapper, deinterleaver, FFT input).

Parameters:
DWIDTH, 32, RAM data width.
AWIDTH, 9, RAM address width; RAM depth is 2^AWIDTH words.

Ports:
clock  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  gates command acceptance and new RAM reads only.
abort  in  1  synchronous burst cancel.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_addr  in  AWIDTH  first RAM address.
cmd_len  in  AWIDTH+1  number of words to read.
ram_en  out  1  RAM port enable; one read per cycle high.
ram_we  out  1  constant 0.
ram_addr  out  AWIDTH  RAM read address.
ram_dout  in  DWIDTH  RAM registered read data; valid the cycle after ram_en.
dout  out  DWIDTH  output word.
dout_valid  out  1  dout holds a word.
dout_ready  in  1  consumer accepts the word when dout_valid & dout_ready.
dout_last  out  1  qualifies the final word of the burst.
done  out  1  one-cycle pulse on the cycle the last word is accepted.
busy  out  1  high from command acceptance until done or abort.

Behaviour:
- Reset: every output is 0; state IDLE; buffer empty; in-flight flag clear.
- Reset overrides abort, and abort overrides everything else.
- States:
  - IDLE: cmd_ready = enable.
    - Accept with cmd_len = 0: stay IDLE, no reads, done pulses the next cycle, busy stays 0.
    - Accept with cmd_len > 0: latch address; remaining count = min(cmd_len, 2^AWIDTH); go to READ.
  - READ: issue a read when enable = 1 and credit allows. Each read uses the current address, then increments it modulo 2^AWIDTH (511 -> 0 wraps silently) and decrements the remaining count. After the final read is issued, go to DRAIN.
  - DRAIN: no reads. When the last word is accepted, pulse done and go to IDLE.
  - cmd_ready is 0 in READ and DRAIN.
- Credit rule: a read may issue only if (buffered words + in-flight word − word popped this cycle) < 2. Use a 2-entry output buffer.
- Throughput: with dout_ready held high, sustain 1 word/cycle with no bubbles.
- Latency, command accepted in cycle T:
  - ram_en = 1 in T+1.
  - ram_dout is valid in T+2 and is captured at the end of T+2.
  - dout_valid = 1 in T+3.
- Data capture: always capture the in-flight word one cycle after its ram_en, whatever the state of enable or dout_ready. The credit rule guarantees there is space.
- Output ordering and stability: words leave in address order. dout, dout_last and dout_valid hold stable while dout_valid & !dout_ready. dout holds its last value when dout_valid = 0.
- dout_last is high with exactly the final word only.
- enable = 0: no new ram_en and no command accept. Capture and output draining continue.
- abort:
  - Next cycle: buffer flushed, in-flight word discarded, dout_valid = 0, busy = 0, state IDLE, no done pulse.
  - An abort in IDLE has no effect.
  - A command presented in the same cycle as abort is not accepted.
- Simultaneous pop and capture with the buffer full: legal; occupancy stays constant.
- ram_we is tied to 0. This block never writes.

Decomposition:
- Package ram_burst_reader_pkg: state encoding (IDLE, READ, DRAIN) and a localparam MAX_LEN = 2^AWIDTH helper.
- Sub-module rx_skid_buf: 2-entry registered FIFO carrying {last, data}. Ports: push, pop, full count, valid, flush.
- The top level holds the FSM, address and length counters, credit logic and in-flight flag.

Test Plan:
- Basic burst: RAM preloaded with ram[i] = i; cmd addr 5, len 4, dout_ready = 1 -> dout 5, 6, 7, 8 on consecutive cycles starting T+3; dout_last on 8; done the same cycle; busy low the next cycle.
- Wrap-around: cmd addr 510, len 4 -> ram_addr 510, 511, 0, 1; dout 510, 511, 0, 1.
- Backpressure: len 6 with dout_ready toggling 1, 0, 0, 1, … -> all 6 words exactly once, in order; data stable while stalled; no more than 2 outstanding (buffered + in-flight) at any time.
- Length edges: len 0 -> no ram_en, done one cycle later; len 600 -> exactly 512 words, ram_addr wraps back to cmd_addr.
- Abort mid-burst: abort in the cycle after the 3rd word is accepted, len 10 -> dout_valid 0 the next cycle, no done, IDLE; a new cmd addr 0, len 2 then returns 0, 1 correctly.
- enable low: len 8 with enable = 0 for 5 cycles mid-burst -> no ram_en during the gap, buffered words still drain, the burst resumes, all 8 words arrive in order.

Source files
------------

// File: rtl/ram_burst_reader_pkg.sv
// Shared types and sizing helpers for the RAM burst read engine.
// Imported by the top level and the testbench.
package ram_burst_reader_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int AWIDTH_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int max_len(input int aw);
        return 1 << aw;
    endfunction

    localparam int MAX_LEN = max_len(AWIDTH_DEF);

endpackage

// File: rtl/ram_burst_reader_if.sv
// Command, RAM-port and output-stream signals of the burst reader.
// Every stream transfers a word on a cycle where valid & ready are both high; valid never waits on ready.
interface ram_burst_reader_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 9
);
    logic              enable;
    logic              abort;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AWIDTH-1:0] cmd_addr;
    logic [AWIDTH:0]   cmd_len;
    logic              ram_en;
    logic              ram_we;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_dout;
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic              done;
    logic              busy;

    modport master (
        input  enable, abort, cmd_valid, cmd_addr, cmd_len, ram_dout, dout_ready,
        output cmd_ready, ram_en, ram_we, ram_addr, dout, dout_valid, dout_last, done, busy
    );

    modport slave (
        output enable, abort, cmd_valid, cmd_addr, cmd_len, ram_dout, dout_ready,
        input  cmd_ready, ram_en, ram_we, ram_addr, dout, dout_valid, dout_last, done, busy
    );
endinterface

// File: rtl/rx_skid_buf.sv
// Two-entry registered FIFO for read words; head register drives the output
// and keeps its last value once the FIFO empties.
module rx_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_i) begin
                        head_d  = data_i;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop_i) begin
                        head_d = data_i;
                    end else if (push_i) begin
                        tail_d  = data_i;
                        count_d = 2'd2;
                    end else if (pop_i) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    // Full: the upstream credit check never pushes here without a pop.
                    if (pop_i) begin
                        head_d = tail_q;
                        if (push_i) tail_d = data_i;
                        else        count_d = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign data_o  = head_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read engine: walks a RAM address range, hides the one-cycle read
// latency and emits the words as a valid/ready stream with last/done markers.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    ram_burst_reader_if.master   bus,
    output state_e               state_o
);
    localparam int              MAX_WORDS = max_len(AWIDTH);
    localparam logic [AWIDTH:0] MAX_LEN_W = MAX_WORDS[AWIDTH:0];

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH:0]   rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              done_q, done_d;

    logic              cmd_ready_c;
    logic              issue;
    logic              pop;
    logic              push;
    logic              credit_ok;
    logic [2:0]        occupancy;
    logic [1:0]        buf_count;
    logic              buf_valid;
    logic [DWIDTH:0]   buf_data;

    assign pop       = buf_valid & bus.dout_ready;
    // A discarded in-flight word must not land in the buffer being flushed.
    assign push      = inflight_q & ~bus.abort;
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = (occupancy < 3'd2);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = 1'b0;
        inflight_last_d = inflight_last_q;
        done_d          = 1'b0;
        cmd_ready_c     = 1'b0;
        issue           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_c = bus.enable & ~bus.abort & ~reset;
                if (bus.cmd_valid && cmd_ready_c) begin
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = bus.cmd_addr;
                        rem_d   = (bus.cmd_len > MAX_LEN_W) ? MAX_LEN_W : bus.cmd_len;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (bus.enable && credit_ok) begin
                    issue           = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_last_d = (rem_q == 1);
                    addr_d          = addr_q + 1'b1;
                    rem_d           = rem_q - 1'b1;
                    if (rem_q == 1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && buf_data[DWIDTH]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort) begin
            state_d    = ST_IDLE;
            inflight_d = 1'b0;
            done_d     = 1'b0;
            issue      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    rx_skid_buf #(
        .W(DWIDTH + 1)
    ) u_buf (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (bus.abort),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({inflight_last_q, bus.ram_dout}),
        .data_o  (buf_data),
        .valid_o (buf_valid),
        .count_o (buf_count)
    );

    assign bus.cmd_ready  = cmd_ready_c;
    assign bus.ram_en     = issue;
    assign bus.ram_we     = 1'b0;
    assign bus.ram_addr   = addr_q;
    assign bus.dout       = buf_data[DWIDTH-1:0];
    assign bus.dout_valid = buf_valid;
    assign bus.dout_last  = buf_valid & buf_data[DWIDTH];
    assign bus.done       = done_q | (pop & buf_data[DWIDTH] & ~bus.abort);
    assign bus.busy       = (state_q != ST_IDLE);
    assign state_o        = state_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: RAM model, command/abort drivers, stream
// scoreboard fed by an address-range model, vector table, corner sequences.
module tb_ram_burst_reader;
    import ram_burst_reader_pkg::*;

    localparam int DW = 32;
    localparam int AW = 9;

    logic   clock = 1'b0;
    logic   reset = 1'b1;
    state_e state_dbg;
    int     cyc = 0;

    ram_burst_reader_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    ram_burst_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.master),
        .state_o (state_dbg)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: registered read, data valid the cycle after ram_en.
    logic [DW-1:0] mem [MAX_LEN];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clock) if (bus.ram_en) ram_q <= mem[bus.ram_addr];
    assign bus.ram_dout = ram_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Scoreboard and per-burst statistics
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    bit            mon_on = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW:0]   prev_word = '0;
    int n_en, n_pop, n_done, first_en, first_valid, last_pop, done_cyc, acc_cyc;
    logic [DW-1:0] first_data, last_data;

    task automatic clear_stats();
        n_en = 0; n_pop = 0; n_done = 0;
        first_en = -1; first_valid = -1; last_pop = -1; done_cyc = -1; acc_cyc = -1;
        first_data = '0; last_data = '0;
        prev_stall = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    // Reference: a burst is the address range a .. a+min(len,MAX_LEN)-1 modulo RAM depth.
    task automatic model_load(input int a, input int l);
        int n;
        int ad;
        n = (l > MAX_LEN) ? MAX_LEN : l;
        for (int k = 0; k < n; k++) begin
            ad = (a + k) % MAX_LEN;
            exp_addr_q.push_back(ad[AW-1:0]);
            exp_q.push_back({(k == n - 1), mem[ad]});
        end
    endtask

    always @(negedge clock) begin
        if (mon_on) begin
            if (prev_stall)
                check("hold_while_stalled", {bus.dout_valid, bus.dout_last, bus.dout}, {1'b1, prev_word});
            if (bus.ram_en) begin
                n_en++;
                if (first_en < 0) first_en = cyc;
                check("ram_we_low", bus.ram_we, 0);
                check("ram_en_needs_enable", bus.enable, 1);
                if (exp_addr_q.size() == 0) fail_msg("ram_en_extra");
                else check("ram_addr", bus.ram_addr, exp_addr_q.pop_front());
            end
            if (bus.dout_valid && first_valid < 0) first_valid = cyc;
            if (bus.dout_valid && bus.dout_ready) begin
                n_pop++;
                if (n_pop == 1) first_data = bus.dout;
                last_data = bus.dout;
                if (bus.dout_last) last_pop = cyc;
                if (exp_q.size() == 0) fail_msg("dout_extra");
                else check("dout_last_data", {bus.dout_last, bus.dout}, exp_q.pop_front());
            end
            if (bus.ram_en) check("outstanding_le_2", (n_en - n_pop <= 2), 1);
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
            end
            prev_stall = bus.dout_valid && !bus.dout_ready;
            prev_word  = {bus.dout_last, bus.dout};
        end
    end

    // Consumer ready / enable drivers: 0 steady high, 1 pattern, 2 random, 3 manual
    int ready_mode = 3;
    int en_mode    = 3;
    int ph = 0;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            ph++;
            case (ready_mode)
                0: bus.dout_ready = 1'b1;
                1: bus.dout_ready = (ph % 3 == 0);
                2: bus.dout_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
            case (en_mode)
                0: bus.enable = 1'b1;
                1: bus.enable = ($urandom_range(0, 3) != 0);
                2: bus.enable = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    task automatic send_cmd(input int a, input int l);
        int k;
        bit got;
        k = 0;
        got = 1'b0;
        model_load(a, l);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a[AW-1:0];
        bus.cmd_len   = l[AW:0];
        while (!got && k < 60) begin
            tick();
            if (bus.cmd_ready) begin
                got = 1'b1;
                acc_cyc = cyc;
            end
            k++;
        end
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        if (!got) fail_msg("cmd_accept_timeout");
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        if (n_done == 0) fail_msg("done_timeout");
    endtask

    typedef struct {
        int addr;
        int len;
        int rmode;
        int exp_n;
        int exp_first;
        int exp_lastw;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit quiet;
        int a;
        int l;
        int n;

        bus.enable = 1'b1; bus.abort = 1'b0; bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0; bus.cmd_len = '0; bus.dout_ready = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) mem[i] = DW'(i);
        clear_stats();

        vecs[0] = '{5,   4,   0, 4,   5,   8};
        vecs[1] = '{510, 4,   0, 4,   510, 1};
        vecs[2] = '{7,   6,   1, 6,   7,   12};
        vecs[3] = '{0,   0,   0, 0,   0,   0};
        vecs[4] = '{100, 600, 0, 512, 100, 99};
        vecs[5] = '{511, 1,   1, 1,   511, 511};
        vecs[6] = '{300, 2,   2, 2,   300, 301};

        // Reset values, with enable high to see cmd_ready held off.
        repeat (3) @(posedge clock);
        tick();
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_dout_last", bus.dout_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_state", state_dbg, ST_IDLE);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        check("idle_cmd_ready", bus.cmd_ready, 1);

        // Vector table
        mon_on = 1'b1;
        for (int i = 0; i < 7; i++) begin
            clear_stats();
            en_mode = 0;
            ready_mode = vecs[i].rmode;
            send_cmd(vecs[i].addr, vecs[i].len);
            wait_done(4000);
            check($sformatf("v%0d_done_count", i), n_done, 1);
            tick();
            check($sformatf("v%0d_busy_after", i), bus.busy, 0);
            check($sformatf("v%0d_state_after", i), state_dbg, ST_IDLE);
            repeat (3) tick();
            check($sformatf("v%0d_ram_en_count", i), n_en, vecs[i].exp_n);
            check($sformatf("v%0d_words", i), n_pop, vecs[i].exp_n);
            check($sformatf("v%0d_model_empty", i), exp_q.size(), 0);
            check($sformatf("v%0d_single_done", i), n_done, 1);
            if (vecs[i].exp_n == 0) begin
                check($sformatf("v%0d_len0_done_lat", i), done_cyc - acc_cyc, 1);
            end else begin
                check($sformatf("v%0d_first_word", i), first_data, vecs[i].exp_first);
                check($sformatf("v%0d_last_word", i), last_data, vecs[i].exp_lastw);
                check($sformatf("v%0d_ram_en_lat", i), first_en - acc_cyc, 1);
                check($sformatf("v%0d_valid_lat", i), first_valid - acc_cyc, 3);
                check($sformatf("v%0d_done_with_last", i), done_cyc, last_pop);
                check($sformatf("v%0d_dout_holds", i), bus.dout, vecs[i].exp_lastw);
                if (vecs[i].rmode == 0)
                    check($sformatf("v%0d_no_bubbles", i), last_pop - first_valid, vecs[i].exp_n - 1);
            end
        end

        // Abort mid-burst, one cycle after the third word is taken.
        clear_stats();
        en_mode = 0;
        ready_mode = 3;
        bus.dout_ready = 1'b1;
        send_cmd(20, 10);
        k = 0;
        while (n_pop < 3 && k < 100) begin tick(); k++; end
        check("abort_pre_pops", n_pop, 3);
        @(posedge clock);
        #1;
        mon_on = 1'b0;
        bus.abort = 1'b1;
        bus.dout_ready = 1'b0;
        tick();
        check("abort_cyc_ram_en", bus.ram_en, 0);
        check("abort_cyc_done", bus.done, 0);
        @(posedge clock);
        #1;
        bus.abort = 1'b0;
        tick();
        check("abort_dout_valid", bus.dout_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_state", state_dbg, ST_IDLE);
        check("abort_no_done", bus.done, 0);
        quiet = 1'b1;
        repeat (4) begin
            tick();
            if (bus.done || bus.dout_valid || bus.ram_en) quiet = 1'b0;
        end
        check("abort_quiet", quiet, 1);
        clear_stats();
        mon_on = 1'b1;
        bus.dout_ready = 1'b1;
        send_cmd(0, 2);
        wait_done(100);
        check("post_abort_words", n_pop, 2);
        check("post_abort_first", first_data, 0);
        check("post_abort_last", last_data, 1);

        // Abort in IDLE together with a command: command must be refused.
        tick();
        clear_stats();
        @(posedge clock);
        #1;
        bus.abort = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr = 9'd3;
        bus.cmd_len = 10'd4;
        tick();
        check("idle_abort_cmd_ready", bus.cmd_ready, 0);
        @(posedge clock);
        #1;
        bus.abort = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (3) tick();
        check("idle_abort_busy", bus.busy, 0);
        check("idle_abort_no_reads", n_en, 0);
        check("idle_abort_state", state_dbg, ST_IDLE);

        // Enable low for five cycles in the middle of a burst.
        clear_stats();
        en_mode = 3;
        bus.enable = 1'b1;
        ready_mode = 0;
        send_cmd(40, 8);
        k = 0;
        while (n_en < 3 && k < 50) begin tick(); k++; end
        @(posedge clock);
        #1;
        bus.enable = 1'b0;
        a = n_en;
        l = n_pop;
        repeat (5) tick();
        check("gap_no_ram_en", n_en, a);
        check("gap_drains", (n_pop > l), 1);
        @(posedge clock);
        #1;
        bus.enable = 1'b1;
        wait_done(200);
        check("gap_words", n_pop, 8);
        check("gap_first", first_data, 40);
        check("gap_last", last_data, 47);
        check("gap_model_empty", exp_q.size(), 0);

        // Randomised bursts over random RAM contents.
        for (int i = 0; i < MAX_LEN; i++) mem[i] = $urandom;
        for (int r = 0; r < 20; r++) begin
            tick();
            clear_stats();
            a = $urandom_range(0, MAX_LEN - 1);
            l = ($urandom_range(0, 9) < 2) ? $urandom_range(0, 1023) : $urandom_range(0, 24);
            n = (l > MAX_LEN) ? MAX_LEN : l;
            ready_mode = $urandom_range(0, 2);
            en_mode = $urandom_range(0, 1);
            send_cmd(a, l);
            wait_done(5000);
            tick();
            check($sformatf("rnd%0d_words", r), n_pop, n);
            check($sformatf("rnd%0d_reads", r), n_en, n);
            check($sformatf("rnd%0d_model_empty", r), exp_q.size(), 0);
            check($sformatf("rnd%0d_busy_after", r), bus.busy, 0);
        end

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
